// File: rtl/interval_timer.sv
// interval_timer: loadable one-shot/periodic down-counter with pause, abort and live remaining count.
// The counter is kept at 0 outside RUN/PAUSED, so remaining can come straight from it.
module interval_timer #(
    parameter int CNT_WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 periodic,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 tick,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] remaining
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_period;
    logic                 r_mode;
    logic                 r_tick;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] w_p;
    logic                 w_active;
    assign w_p      = (period == '0) ? CNT_WIDTH'(1) : period;
    assign w_active = (r_state == RUN) || (r_state == PAUSED);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_mode   <= 1'b0;
            r_tick   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (stop) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_state  <= RUN;
            r_period <= w_p;
            r_mode   <= periodic;
            r_cnt    <= w_p - CNT_WIDTH'(1);
            r_tick   <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (w_active) begin
            // leaving PAUSED counts on the same edge, so a pause costs exactly its length
            if (pause) begin
                r_state <= PAUSED;
                r_tick  <= 1'b0;
            end else if (r_cnt != '0) begin
                r_state <= RUN;
                r_cnt   <= r_cnt - CNT_WIDTH'(1);
                r_tick  <= 1'b0;
            end else if (r_mode) begin
                r_state <= RUN;
                r_cnt   <= r_period - CNT_WIDTH'(1);
                r_tick  <= 1'b1;
            end else begin
                r_state <= DONE;
                r_cnt   <= '0;
                r_tick  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_cnt;
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scenario tasks with a queue scoreboard of expected per-cycle outputs.
module tb_interval_timer;
    localparam int W = 28;
    typedef struct packed {
        logic         tick;
        logic         busy;
        logic         done;
        logic [W-1:0] rem;
    } out_t;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         periodic = 1'b0;
    logic [W-1:0] period = '0;
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] remaining;
    out_t         exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    interval_timer #(.CNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .period(period), .tick(tick), .busy(busy),
        .done(done), .remaining(remaining)
    );
    always #5 clk = ~clk;
    // expected outputs e edges after a start of effective period p
    function automatic out_t exp_run(input int p, input int e, input bit per);
        out_t r;
        r = '0;
        if (per || e < p) begin
            r.tick = (e > 0) && (e % p == 0);
            r.busy = 1'b1;
            r.rem  = W'(p - 1 - e % p);
        end else begin
            r.tick = (e == p);
            r.done = 1'b1;
        end
        return r;
    endfunction
    task automatic test_reset;
        out_t e, g;
        reset = 1'b1;
        exp_q.push_back('0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
        if (g !== e) begin n_err++; $display("FAIL reset_init got=%h exp=%h", g, e); end
        reset = 1'b0; period = W'(10); periodic = 1'b0;
        for (int j = 0; j < 10; j++) begin
            start = (j == 0);
            reset = (j == 4);
            exp_q.push_back((j >= 4) ? out_t'('0) : exp_run(10, j, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL reset_midrun j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0; reset = 1'b0;
    endtask
    task automatic test_oneshot;
        out_t e, g;
        period = W'(5); periodic = 1'b0;
        for (int j = 0; j < 9; j++) begin
            start = (j == 0);
            exp_q.push_back(exp_run(5, j, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL oneshot j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0;
    endtask
    task automatic test_periodic;
        out_t e, g;
        int   n_ticks = 0;
        period = W'(3); periodic = 1'b1;
        for (int j = 0; j < 17; j++) begin
            start = (j == 0);
            stop  = (j == 13);
            exp_q.push_back((j >= 13) ? out_t'('0) : exp_run(3, j, 1'b1));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (j <= 12 && g.tick) n_ticks++;
            if (g !== e) begin n_err++; $display("FAIL periodic j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0; stop = 1'b0;
        n_vec++;
        if (n_ticks !== 4) begin n_err++; $display("FAIL periodic_tick_count got=%0d exp=4", n_ticks); end
    endtask
    task automatic test_pause;
        out_t e, g;
        int   eff;
        period = W'(6); periodic = 1'b1;
        for (int j = 0; j < 20; j++) begin
            start = (j == 0);
            pause = (j >= 4 && j <= 7);
            stop  = (j == 18);
            eff   = (j <= 3) ? j : (j <= 7) ? 3 : j - 4;
            exp_q.push_back((j >= 18) ? out_t'('0) : exp_run(6, eff, 1'b1));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL pause j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask
    task automatic test_zero_period;
        out_t e, g;
        period = '0; periodic = 1'b1;
        for (int j = 0; j < 5; j++) begin
            start = (j == 0);
            exp_q.push_back(exp_run(1, j, 1'b1));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL zero_periodic j=%0d got=%h exp=%h", j, g, e); end
        end
        periodic = 1'b0;
        for (int j = 0; j < 4; j++) begin
            start = (j == 0);
            exp_q.push_back(exp_run(1, j, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL zero_oneshot j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0;
    endtask
    task automatic test_restart;
        out_t e, g;
        periodic = 1'b0;
        for (int j = 0; j < 13; j++) begin
            start  = (j == 0) || (j == 2);
            period = (j == 0) ? W'(5) : (j == 2) ? W'(8) : W'(2);
            exp_q.push_back((j < 2) ? exp_run(5, j, 1'b0) : exp_run(8, j - 2, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL restart j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0;
    endtask
    task automatic test_start_stop;
        out_t e, g;
        period = W'(4); periodic = 1'b1;
        for (int j = 0; j < 6; j++) begin
            start = (j == 0) || (j == 2) || (j == 4);
            stop  = (j == 0) || (j == 4);
            exp_q.push_back((j == 2 || j == 3) ? exp_run(4, j - 2, 1'b1) : out_t'('0));
            @(posedge clk); #1;
            e = exp_q.pop_front(); g = {tick, busy, done, remaining}; n_vec++;
            if (g !== e) begin n_err++; $display("FAIL start_stop j=%0d got=%h exp=%h", j, g, e); end
        end
        start = 1'b0; stop = 1'b0;
    endtask
    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_zero_period();
        test_restart();
        test_start_stop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
